// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR matrix job sequencer.
package fir_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadTap,
        StStream,
        StGap,
        StWaitRes,
        StDone
    } ctrl_state_e;

    // Valid-convolution output count for a tr x tc kernel over a dr x dc frame.
    function automatic int unsigned n_results(input int unsigned tr, input int unsigned tc,
                                              input int unsigned dr, input int unsigned dc);
        return (dr - tr + 1) * (dc - tc + 1);
    endfunction

endpackage

// File: rtl/fir_matrix_ctrl.sv
// Job sequencer for the FIR DSP-matrix core: loads taps, streams one frame with
// inter-row gaps, then counts results and reports done or timeout.
module fir_matrix_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned TAP_ROW    = 3,
    parameter int unsigned TAP_COL    = 3,
    parameter int unsigned TAP_WIDTH  = 8,
    parameter int unsigned DATA_ROW   = 16,
    parameter int unsigned DATA_COL   = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROW_GAP    = 16,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [TAP_WIDTH-1:0]  tap_in_i,
    input  logic                  tap_in_vld_i,
    output logic                  tap_in_rdy_o,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  data_in_vld_i,
    output logic                  data_in_rdy_o,
    output logic [TAP_WIDTH-1:0]  tap_o,
    output logic                  tap_vld_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_vld_o,
    input  logic [31:0]           core_result_i,
    input  logic                  core_result_vld_i,
    output logic [31:0]           result_o,
    output logic                  result_vld_o,
    output logic [15:0]           result_cnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_timeout_o
);

    localparam int unsigned N_TAPS = TAP_ROW * TAP_COL;
    localparam int unsigned N_RES  = n_results(TAP_ROW, TAP_COL, DATA_ROW, DATA_COL);
    localparam int unsigned TW     = $clog2(N_TAPS + 1);
    localparam int unsigned TOW    = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0]  TAP_LAST = TW'(N_TAPS - 1);
    localparam logic [9:0]     COL_LAST = 10'(DATA_COL - 1);
    localparam logic [9:0]     ROW_LAST = 10'(DATA_ROW - 1);
    localparam logic [9:0]     GAP_LAST = 10'(ROW_GAP - 1);
    localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);
    localparam logic [15:0]    N_RES_W  = 16'(N_RES);

    // The core zero-stuffs its FIFO for DATA_COL cycles after each row.
    if (ROW_GAP < DATA_COL) begin : gen_bad_gap
        $error("ROW_GAP must be >= DATA_COL");
    end
    if (N_RES >= 65536) begin : gen_bad_nres
        $error("result count does not fit in 16 bits");
    end

    ctrl_state_e           state_q, state_d;
    logic [TW-1:0]         tap_cnt_q, tap_cnt_d;
    logic [9:0]            col_cnt_q, col_cnt_d;
    logic [9:0]            row_cnt_q, row_cnt_d;
    logic [9:0]            gap_cnt_q, gap_cnt_d;
    logic [TOW-1:0]        timeout_cnt_q, timeout_cnt_d;
    logic [15:0]           result_cnt_q, result_cnt_d;
    logic                  err_q, err_d;
    logic [TAP_WIDTH-1:0]  tap_q;
    logic                  tap_vld_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  data_vld_q;
    logic [31:0]           result_q;
    logic                  result_vld_q;
    logic                  tap_fire, data_fire;

    assign tap_in_rdy_o  = (state_q == StLoadTap);
    assign data_in_rdy_o = (state_q == StStream);
    assign tap_fire      = tap_in_vld_i && tap_in_rdy_o;
    assign data_fire     = data_in_vld_i && data_in_rdy_o;

    always_comb begin
        state_d       = state_q;
        tap_cnt_d     = tap_cnt_q;
        col_cnt_d     = col_cnt_q;
        row_cnt_d     = row_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        err_d         = err_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StLoadTap;
                    err_d     = 1'b0;
                    tap_cnt_d = '0;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
                end
            end
            StLoadTap: begin
                if (tap_fire) begin
                    if (tap_cnt_q == TAP_LAST) begin
                        tap_cnt_d = '0;
                        state_d   = StStream;
                    end else begin
                        tap_cnt_d = tap_cnt_q + 1'b1;
                    end
                end
            end
            StStream: begin
                if (data_fire) begin
                    if (col_cnt_q == COL_LAST) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + 10'd1;
                        gap_cnt_d = '0;
                        if (row_cnt_q == ROW_LAST) begin
                            timeout_cnt_d = '0;
                            state_d       = StWaitRes;
                        end else begin
                            state_d = StGap;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + 10'd1;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = StStream;
                end else begin
                    gap_cnt_d = gap_cnt_q + 10'd1;
                end
            end
            StWaitRes: begin
                if (result_cnt_q == N_RES_W) begin
                    state_d = StDone;
                end else if (timeout_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Results are counted in any active state so early core output is not lost.
    always_comb begin
        result_cnt_d = result_cnt_q;
        if (state_q == StIdle) begin
            if (start_i) begin
                result_cnt_d = '0;
            end
        end else if (core_result_vld_i && (result_cnt_q != N_RES_W)) begin
            result_cnt_d = result_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            tap_cnt_q     <= '0;
            col_cnt_q     <= '0;
            row_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            timeout_cnt_q <= '0;
            result_cnt_q  <= '0;
            err_q         <= 1'b0;
            tap_q         <= '0;
            tap_vld_q     <= 1'b0;
            data_q        <= '0;
            data_vld_q    <= 1'b0;
            result_q      <= '0;
            result_vld_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            tap_cnt_q     <= tap_cnt_d;
            col_cnt_q     <= col_cnt_d;
            row_cnt_q     <= row_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            result_cnt_q  <= result_cnt_d;
            err_q         <= err_d;
            tap_vld_q     <= tap_fire;
            data_vld_q    <= data_fire;
            result_vld_q  <= core_result_vld_i;
            if (tap_fire) begin
                tap_q <= tap_in_i;
            end
            if (data_fire) begin
                data_q <= data_in_i;
            end
            if (core_result_vld_i) begin
                result_q <= core_result_i;
            end
        end
    end

    assign tap_o         = tap_q;
    assign tap_vld_o     = tap_vld_q;
    assign data_o        = data_q;
    assign data_vld_o    = data_vld_q;
    assign result_o      = result_q;
    assign result_vld_o  = result_vld_q;
    assign result_cnt_o  = result_cnt_q;
    assign err_timeout_o = err_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);

endmodule

// File: tb/tb_fir_matrix_ctrl.sv
// Scoreboard bench for fir_matrix_ctrl: drivers push expected outputs, monitors pop and compare.
module tb_fir_matrix_ctrl;

    localparam int DATA_COL = 16;
    localparam int ROW_GAP  = 16;
    localparam int N_PIX    = 256;
    localparam int N_TAPS   = 9;
    localparam int N_RES    = 196;
    localparam int TIMEOUT  = 4096;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  tap_in_i = '0;
    logic        tap_in_vld_i = 1'b0;
    logic        tap_in_rdy_o;
    logic [15:0] data_in_i = '0;
    logic        data_in_vld_i = 1'b0;
    logic        data_in_rdy_o;
    logic [7:0]  tap_o;
    logic        tap_vld_o;
    logic [15:0] data_o;
    logic        data_vld_o;
    logic [31:0] core_result_i = '0;
    logic        core_result_vld_i = 1'b0;
    logic [31:0] result_o;
    logic        result_vld_o;
    logic [15:0] result_cnt_o;
    logic        busy_o;
    logic        done_o;
    logic        err_timeout_o;

    fir_matrix_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start_i           (start_i),
        .tap_in_i          (tap_in_i),
        .tap_in_vld_i      (tap_in_vld_i),
        .tap_in_rdy_o      (tap_in_rdy_o),
        .data_in_i         (data_in_i),
        .data_in_vld_i     (data_in_vld_i),
        .data_in_rdy_o     (data_in_rdy_o),
        .tap_o             (tap_o),
        .tap_vld_o         (tap_vld_o),
        .data_o            (data_o),
        .data_vld_o        (data_vld_o),
        .core_result_i     (core_result_i),
        .core_result_vld_i (core_result_vld_i),
        .result_o          (result_o),
        .result_vld_o      (result_vld_o),
        .result_cnt_o      (result_cnt_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_timeout_o     (err_timeout_o)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   first_pix = 0;
    int   last_hs = 0;
    int   rdy_low = 0;
    exp_t tap_exp_q[$];
    exp_t pix_exp_q[$];
    exp_t res_exp_q[$];
    exp_t te, pe, re;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_o) done_seen <= done_seen + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Monitors
    always @(negedge clk) begin
        if (reset && tap_vld_o) begin
            if (tap_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tap_extra: got %0h, expected no tap", tap_o);
            end else begin
                te = tap_exp_q.pop_front();
                check("tap_val", 32'(tap_o), te.val);
                check("tap_lat", cyc, te.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && data_vld_o) begin
            if (pix_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pix_extra: got %0h, expected no pixel", data_o);
            end else begin
                pe = pix_exp_q.pop_front();
                if (pe.idx == 0) first_pix = cyc;
                check("pix_val", 32'(data_o), pe.val);
                check("pix_lat", cyc, pe.cyc);
                check("pix_slot", cyc - first_pix, pe.idx + ROW_GAP * (pe.idx / DATA_COL));
            end
        end
    end

    always @(negedge clk) begin
        if (reset && result_vld_o) begin
            if (res_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL res_extra: got %0h, expected no result", result_o);
            end else begin
                re = res_exp_q.pop_front();
                check("res_val", result_o, re.val);
                check("res_lat", cyc, re.cyc);
            end
        end
    end

    // Drivers
    task automatic start_job();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 1);
        check("err_clear_on_start", 32'(err_timeout_o), 0);
        check("cnt_clear_on_start", 32'(result_cnt_o), 0);
    endtask

    task automatic send_taps();
        int i = 0;
        int g = 0;
        while (i < N_TAPS && g < 200) begin
            @(negedge clk);
            tap_in_vld_i = 1'b1;
            tap_in_i = 8'(i + 1);
            if (tap_in_rdy_o) begin
                tap_exp_q.push_back('{32'(i + 1), cyc + 1, i});
                i++;
            end
            g++;
        end
        if (i < N_TAPS) fail_now("tap_handshake");
        @(negedge clk);
        tap_in_vld_i = 1'b0;
        check("stream_after_taps", 32'(data_in_rdy_o), 1);
    endtask

    task automatic send_pixels(input int stop_at, input int pulse_at);
        int i = 0;
        int g = 0;
        bit pulsed = 0;
        rdy_low = 0;
        while (i < stop_at && g < 2000) begin
            @(negedge clk);
            start_i = 1'b0;
            if (i == pulse_at && !pulsed) begin
                start_i = 1'b1;
                pulsed = 1;
            end
            data_in_vld_i = 1'b1;
            data_in_i = 16'h1000 + 16'(i);
            if (data_in_rdy_o) begin
                pix_exp_q.push_back('{32'(16'h1000 + 16'(i)), cyc + 1, i});
                last_hs = cyc + 1;
                i++;
            end else if (i > 0) begin
                rdy_low++;
            end
            g++;
        end
        if (i < stop_at) fail_now("pix_handshake");
    endtask

    task automatic send_results(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            core_result_vld_i = 1'b1;
            core_result_i = 32'hC0DE_0000 + 32'(k * 3);
            res_exp_q.push_back('{32'hC0DE_0000 + 32'(k * 3), cyc + 1, k});
        end
        @(negedge clk);
        core_result_vld_i = 1'b0;
    endtask

    task automatic wait_done(input int exp_seen);
        int g = 0;
        while (!done_o && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!done_o) begin
            fail_now("done_wait");
        end else begin
            check("cnt_at_done", 32'(result_cnt_o), N_RES);
            check("busy_at_done", 32'(busy_o), 1);
        end
        @(negedge clk);
        check("busy_after_done", 32'(busy_o), 0);
        check("done_one_cycle", 32'(done_o), 0);
        @(negedge clk);
        check("done_pulses", done_seen, exp_seen);
        check("tap_q_drained", tap_exp_q.size(), 0);
        check("pix_q_drained", pix_exp_q.size(), 0);
        check("res_q_drained", res_exp_q.size(), 0);
    endtask

    task automatic full_job(input int pulse_at, input int exp_seen);
        start_job();
        send_taps();
        send_pixels(N_PIX, pulse_at);
        @(negedge clk);
        data_in_vld_i = 1'b0;
        start_i = 1'b0;
        check("gap_rdy_low_cycles", rdy_low, 15 * ROW_GAP);
        send_results(N_RES);
        wait_done(exp_seen);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tap_vld"}, 32'(tap_vld_o), 0);
        check({tag, "_data_vld"}, 32'(data_vld_o), 0);
        check({tag, "_data"}, 32'(data_o), 0);
        check({tag, "_res_vld"}, 32'(result_vld_o), 0);
        check({tag, "_res_cnt"}, 32'(result_cnt_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_err"}, 32'(err_timeout_o), 0);
        check({tag, "_data_rdy"}, 32'(data_in_rdy_o), 0);
        check({tag, "_tap_rdy"}, 32'(tap_in_rdy_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        #13;
        check_all_zero("reset");
        check("reset_tap", 32'(tap_o), 0);
        @(negedge clk);
        reset = 1'b1;

        // Job 1: full run with a stray start during STREAM.
        full_job(50, 1);

        // Job 2: core delivers too few results, so the job must time out.
        start_job();
        send_taps();
        send_pixels(N_PIX, -1);
        @(negedge clk);
        data_in_vld_i = 1'b0;
        send_results(100);
        g = 0;
        while (busy_o && g < 6000) begin
            @(negedge clk);
            g++;
        end
        if (busy_o) fail_now("timeout_wait");
        check("timeout_cycles", cyc - last_hs, TIMEOUT);
        check("timeout_err", 32'(err_timeout_o), 1);
        check("timeout_cnt", 32'(result_cnt_o), 100);
        @(negedge clk);
        check("timeout_no_done", done_seen, 1);

        // Job 3: reset lands while pixel 37 is offered.
        start_job();
        send_taps();
        send_pixels(37, -1);
        @(negedge clk);
        data_in_i = 16'h1000 + 16'd37;
        data_in_vld_i = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async");
        tap_exp_q.delete();
        pix_exp_q.delete();
        res_exp_q.delete();
        data_in_vld_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("reset_no_done", done_seen, 1);

        // Job 4: fresh job after reset.
        full_job(-1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_matrix_ctrl.md
Name: fir_matrix_ctrl

Overview:
Job sequencer in front of the FIR DSP-matrix core. On start_i it loads TAP_ROW*TAP_COL taps, then streams one DATA_ROW x DATA_COL frame row by row with inter-row gaps, so the core's zero-stuffing of its input FIFO never collides with live data. It then collects and counts valid results and reports done or timeout. It sits between the host/DMA streams and the core.

Parameters:
TAP_ROW, 3, kernel rows
TAP_COL, 3, kernel columns
TAP_WIDTH, 8, tap bits
DATA_ROW, 16, frame rows
DATA_COL, 16, frame columns
DATA_WIDTH, 16, pixel bits
ROW_GAP, 16, idle cycles inserted after each streamed row (must be >= DATA_COL)
TIMEOUT, 4096, maximum cycles in WAIT_RES before error

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start_i  in  1  single-cycle job start; ignored unless IDLE
tap_in_i  in  TAP_WIDTH  host tap stream
tap_in_vld_i  in  1  tap valid
tap_in_rdy_o  out  1  tap ready
data_in_i  in  DATA_WIDTH  host pixel stream
data_in_vld_i  in  1  pixel valid
data_in_rdy_o  out  1  pixel ready
tap_o  out  TAP_WIDTH  tap to core
tap_vld_o  out  1  tap shift strobe to core
data_o  out  DATA_WIDTH  pixel to core
data_vld_o  out  1  pixel strobe to core
core_result_i  in  32  core result
core_result_vld_i  in  1  core result valid
result_o  out  32  registered result
result_vld_o  out  1  result valid
result_cnt_o  out  16  results delivered in current job
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse on successful completion
err_timeout_o  out  1  sticky timeout flag; cleared by next accepted start_i

Behaviour:
- Reset asserted: state IDLE; all outputs 0; all counters 0. Reset asserted mid-job aborts the job; no done_o is produced.
- A transfer occurs only when vld and rdy are both 1. rdy_o is combinational from state only and never depends on vld.
- States:
  - IDLE: start_i -> LOAD_TAP; err_timeout_o <= 0, result_cnt_o <= 0; busy_o=1 from the next cycle.
  - LOAD_TAP: tap_in_rdy_o=1. Each transfer drives tap_o/tap_vld_o registered (1-cycle latency). After TAP_ROW*TAP_COL transfers -> STREAM.
  - STREAM: data_in_rdy_o=1. Each transfer drives data_o/data_vld_o registered (1-cycle latency). col_cnt wraps at DATA_COL-1, then row_cnt++ and -> GAP. If this was the last row -> WAIT_RES instead.
  - GAP: rdy=0 for exactly ROW_GAP cycles (gap counter), then -> STREAM.
  - WAIT_RES: timeout counter runs. When result_cnt reaches N_RES=(DATA_ROW-TAP_ROW+1)*(DATA_COL-TAP_COL+1) -> DONE. If TIMEOUT cycles elapse first: err_timeout_o <= 1, -> IDLE, no done_o.
  - DONE: done_o=1 for one cycle; -> IDLE (busy_o=0).
- Results: in every state, core_result_vld_i registers into result_o/result_vld_o (1-cycle latency); result_cnt_o increments only outside IDLE and saturates at N_RES. Extra results after N_RES are still forwarded but not counted.
- start_i while not IDLE: ignored, no side effects.
- Host stalls (vld=0) simply hold counters; there is no stall timeout before WAIT_RES.
- Elaboration checks: ROW_GAP >= DATA_COL; N_RES < 2^16.
- Counters: tap counter $clog2(TAP_ROW*TAP_COL+1) bits; col/row counters 10 bits; timeout counter $clog2(TIMEOUT+1) bits.

Decomposition:
- Package fir_pkg: ctrl_state_e enum (IDLE, LOAD_TAP, STREAM, GAP, WAIT_RES, DONE) and function n_results(tr,tc,dr,dc).
- Single module; no sub-module needed. Optionally reuse a generic fir_counter for col/row/gap counters.

Test Plan:
- Defaults, start_i, 9 taps 1..9 back-to-back -> tap_vld_o high 9 cycles, tap_o=1..9, each 1 cycle after its handshake; state then STREAM.
- 256 pixels with vld always 1 -> data_vld_o in 16 bursts of 16, each followed by exactly 16 idle cycles; data_in_rdy_o low during gaps.
- Model core returns 196 results -> result_cnt_o=196, done_o pulse once, busy_o low the next cycle.
- Core returns only 100 results -> after 4096 WAIT_RES cycles err_timeout_o=1, no done_o, IDLE; next start_i clears err_timeout_o.
- start_i pulsed during STREAM -> ignored; counts and output stream unchanged.
- Reset asserted at pixel 37, then released -> all outputs 0 immediately (asynchronous); fresh job runs to done with correct counts.
